// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, word-addressed instruction memory
// and the IF/ID pipeline register, with stall, flush and branch/jump redirects.
module mips_fetch_stage #(
    parameter int unsigned IMEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    input  logic                          jump,
    input  logic [25:0]                   jump_index,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   Instruction,
    output logic [31:0]                   if_id_pc4,
    output logic                          if_id_valid,
    output logic [31:0]                   fetch_count
);

    localparam int unsigned AddrWidth = $clog2(IMEM_DEPTH);

    logic [31:0]          imem [IMEM_DEPTH];
    logic [AddrWidth-1:0] fetchIdx;
    logic [31:0]          fetchWord;
    logic [31:0]          pcPlus4;
    logic [31:0]          pcNext;
    logic                 redirect;
    logic                 bubble;
    logic                 loadValid;

    // Upper PC bits are dropped so fetches beyond the depth wrap around.
    assign fetchIdx  = pc[AddrWidth+1:2];
    assign fetchWord = imem[fetchIdx];
    assign pcPlus4   = pc + 32'd4;
    assign redirect  = jump | branch_taken;
    assign bubble    = redirect | flush;
    assign loadValid = !bubble && !stall;

    always_comb begin
        pcNext = pcPlus4;
        if (jump) begin
            pcNext = {if_id_pc4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            pcNext = {branch_target[31:2], 2'b00};
        end else if (stall) begin
            pcNext = pc;
        end
    end

    // Memory is deliberately outside the reset domain so programs survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            Instruction <= 32'h0000_0000;
            if_id_pc4   <= 32'h0000_0000;
            if_id_valid <= 1'b0;
            fetch_count <= 32'h0000_0000;
        end else begin
            pc <= pcNext;
            if (bubble) begin
                Instruction <= 32'h0000_0000;
                if_id_pc4   <= 32'h0000_0000;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                Instruction <= fetchWord;
                if_id_pc4   <= pcPlus4;
                if_id_valid <= 1'b1;
            end
            if (loadValid) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: sequential fetch, stall, flush, redirect
// priority, index wrap, same-edge program write and asynchronous reset.
module tb_mips_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        imem_we;
    logic [4:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic [31:0] Instruction;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;

    mips_fetch_stage #(
        .IMEM_DEPTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .pc           (pc),
        .Instruction  (Instruction),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [31:0] ePc, input logic [31:0] eIns,
                          input logic [31:0] ePc4, input logic eValid, input logic [31:0] eCnt);
        chk({tag, ".pc"}, pc, ePc);
        chk({tag, ".instr"}, Instruction, eIns);
        chk({tag, ".pc4"}, if_id_pc4, ePc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, eValid});
        chk({tag, ".count"}, fetch_count, eCnt);
    endtask

    task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] t,
                         input logic j, input logic [25:0] idx);
        stall         = s;
        flush         = f;
        branch_taken  = b;
        branch_target = t;
        jump          = j;
        jump_index    = idx;
    endtask

    // Apply the current inputs for one edge, then idle them.
    task automatic step();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        imem_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;
        #1;
        chkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        // Program load while still in reset.
        for (int i = 0; i < 32; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 5'(i);
            imem_wdata = (i < 4) ? 32'(11 * (i + 1)) : 32'h100 + 32'(i);
            step();
        end
        chkAll("held_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst_n = 1'b1;

        step(); chkAll("seq1", 32'd4, 32'd11, 32'd4, 1'b1, 32'd1);
        step(); chkAll("seq2", 32'd8, 32'd22, 32'd8, 1'b1, 32'd2);
        stall = 1'b1; step(); chkAll("stall1", 32'd8, 32'd22, 32'd8, 1'b1, 32'd2);
        stall = 1'b1; step(); chkAll("stall2", 32'd8, 32'd22, 32'd8, 1'b1, 32'd2);
        step(); chkAll("unstall", 32'd12, 32'd33, 32'd12, 1'b1, 32'd3);
        step(); chkAll("seq4", 32'd16, 32'd44, 32'd16, 1'b1, 32'd4);

        drive(1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 26'h0);
        step(); chkAll("br_stall", 32'd16, 32'h0, 32'h0, 1'b0, 32'd4);
        step(); chkAll("br_next", 32'd20, 32'h104, 32'd20, 1'b1, 32'd5);

        drive(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 26'h6);
        step(); chkAll("jmp_wins", 32'h18, 32'h0, 32'h0, 1'b0, 32'd5);
        step(); chkAll("jmp_next", 32'h1C, 32'h106, 32'h1C, 1'b1, 32'd6);

        flush = 1'b1; step(); chkAll("flush", 32'h20, 32'h0, 32'h0, 1'b0, 32'd6);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        step(); chkAll("flush_stall", 32'h20, 32'h0, 32'h0, 1'b0, 32'd6);
        step(); chkAll("post_flush", 32'h24, 32'h108, 32'h24, 1'b1, 32'd7);

        // Jump region comes from the held PC+4, not from the fetch PC.
        drive(1'b0, 1'b0, 1'b1, 32'hF000_0000, 1'b0, 26'h0);
        step(); chkAll("br_high", 32'hF000_0000, 32'h0, 32'h0, 1'b0, 32'd7);
        step(); chkAll("high_fetch", 32'hF000_0004, 32'd11, 32'hF000_0004, 1'b1, 32'd8);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h1);
        step(); chkAll("jmp_region", 32'hF000_0004, 32'h0, 32'h0, 1'b0, 32'd8);
        step(); chkAll("jmp_region2", 32'hF000_0008, 32'd22, 32'hF000_0008, 1'b1, 32'd9);

        drive(1'b0, 1'b0, 1'b1, 32'h0000_007C, 1'b0, 26'h0);
        step(); chkAll("br_7c", 32'h7C, 32'h0, 32'h0, 1'b0, 32'd9);
        step(); chkAll("last_word", 32'h80, 32'h11F, 32'h80, 1'b1, 32'd10);
        step(); chkAll("wrap", 32'h84, 32'd11, 32'h84, 1'b1, 32'd11);

        drive(1'b0, 1'b0, 1'b1, 32'd20, 1'b0, 26'h0);
        step(); chkAll("to20", 32'd20, 32'h0, 32'h0, 1'b0, 32'd11);
        imem_we = 1'b1; imem_waddr = 5'd5; imem_wdata = 32'h0000_DEAD;
        step(); chkAll("wr_old", 32'd24, 32'h105, 32'd24, 1'b1, 32'd12);
        drive(1'b0, 1'b0, 1'b1, 32'd20, 1'b0, 26'h0);
        step(); chkAll("to20b", 32'd20, 32'h0, 32'h0, 1'b0, 32'd12);
        step(); chkAll("wr_new", 32'd24, 32'h0000_DEAD, 32'd24, 1'b1, 32'd13);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1 chkAll("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        step();
        rst_n = 1'b1;
        chkAll("rst_release", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        step(); chkAll("kept0", 32'd4, 32'd11, 32'd4, 1'b1, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 32'd20, 1'b0, 26'h0);
        step(); chkAll("to20c", 32'd20, 32'h0, 32'h0, 1'b0, 32'd1);
        step(); chkAll("kept5", 32'd24, 32'h0000_DEAD, 32'd24, 1'b1, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
